// File: rtl/io_load_sequencer.sv
// io_load_sequencer: host-driven loader, execution controller and result readout for a processing unit
module io_load_sequencer #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_data,
    output logic [DATA_W-1:0] pru_in,
    output logic [2:0]        pru_io_opcode,
    output logic              pru_reset_execution,
    output logic              pru_enable_execution,
    input  logic              pru_done_execution,
    input  logic [DATA_W-1:0] pru_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              error,
    output logic [31:0]       cycle_count
);
    typedef enum logic [2:0] {IDLE, LOAD, EXEC_RST, EXEC_RUN, RD_ISSUE, RD_WAIT, RD_HOLD, ERR} state_t;
    localparam logic [31:0] TO = 32'(TIMEOUT);
    localparam logic [7:0]  RL = 8'(READ_LAT - 1);
    state_t      state;
    logic [2:0]  cmd;
    logic [15:0] cnt, idx;
    logic [31:0] run_cnt;
    logic [7:0]  wcnt;
    logic [3:0]  hdr_cmd;
    logic [15:0] hdr_n;
    logic        accept;
    logic [31:0] run_nxt;
    assign hdr_cmd = host_data[DATA_W-1 -: 4];
    assign hdr_n   = host_data[15:0];
    assign accept  = host_valid && host_ready;
    assign run_nxt = run_cnt + 32'd1;
    assign busy    = state != IDLE;
    // Sequencer FSM; every processor and host output is registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            host_ready           <= 1'b0;
            pru_in               <= '0;
            pru_io_opcode        <= 3'd0;
            pru_reset_execution  <= 1'b0;
            pru_enable_execution <= 1'b0;
            res_valid            <= 1'b0;
            res_data             <= '0;
            error                <= 1'b0;
            cycle_count          <= '0;
            cmd                  <= '0;
            cnt                  <= '0;
            idx                  <= '0;
            run_cnt              <= '0;
            wcnt                 <= '0;
        end else begin
            pru_io_opcode       <= 3'd0;
            pru_in              <= '0;
            pru_reset_execution <= 1'b0;
            case (state)
                IDLE: begin
                    host_ready <= 1'b1;
                    if (accept) begin
                        cnt <= hdr_n;
                        idx <= '0;
                        cmd <= hdr_cmd[2:0];
                        case (hdr_cmd)
                            4'd1, 4'd2, 4'd3: if (hdr_n != 16'd0) state <= LOAD;
                            4'd4: begin
                                state               <= EXEC_RST;
                                host_ready          <= 1'b0;
                                pru_reset_execution <= 1'b1;
                            end
                            4'd5: if (hdr_n != 16'd0) begin
                                state         <= RD_ISSUE;
                                host_ready    <= 1'b0;
                                pru_io_opcode <= 3'd4;
                            end
                            default: begin
                                state      <= ERR;
                                host_ready <= 1'b0;
                                error      <= 1'b1;
                            end
                        endcase
                    end
                end
                LOAD: if (accept) begin
                    pru_io_opcode <= cmd;
                    pru_in        <= host_data;
                    cnt           <= cnt - 16'd1;
                    if (cnt == 16'd1) state <= IDLE;
                end
                EXEC_RST: begin
                    state                <= EXEC_RUN;
                    pru_enable_execution <= 1'b1;
                    run_cnt              <= '0;
                end
                EXEC_RUN: begin
                    if (pru_done_execution) begin
                        pru_enable_execution <= 1'b0;
                        cycle_count          <= run_nxt;
                        host_ready           <= 1'b1;
                        state                <= IDLE;
                    end else if (run_nxt == TO) begin
                        pru_enable_execution <= 1'b0;
                        error                <= 1'b1;
                        state                <= ERR;
                    end else begin
                        run_cnt <= run_nxt;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                    wcnt  <= '0;
                end
                RD_WAIT: begin
                    if (wcnt == RL) begin
                        res_data  <= pru_out;
                        res_valid <= 1'b1;
                        state     <= RD_HOLD;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                RD_HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (idx + 16'd1 == cnt) begin
                        state      <= IDLE;
                        host_ready <= 1'b1;
                    end else begin
                        idx           <= idx + 16'd1;
                        pru_in        <= DATA_W'(idx + 16'd1);
                        pru_io_opcode <= 3'd4;
                        state         <= RD_ISSUE;
                    end
                end
                default: begin
                    host_ready <= 1'b0;
                    error      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_load_sequencer.sv
// tb_io_load_sequencer: directed checks of load, execute, readout, timeout, error and reset behaviour
module tb_io_load_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [31:0] host_data = '0;
    logic [31:0] pru_in;
    logic [2:0]  pru_io_opcode;
    logic        pru_reset_execution;
    logic        pru_enable_execution;
    logic        pru_done_execution = 1'b0;
    logic [31:0] pru_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;
    logic        error;
    logic [31:0] cycle_count;
    int tests = 0;
    int fails = 0;
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_i = '0, p2_i = '0;

    io_load_sequencer #(.DATA_W(32), .READ_LAT(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
        .pru_in(pru_in), .pru_io_opcode(pru_io_opcode),
        .pru_reset_execution(pru_reset_execution), .pru_enable_execution(pru_enable_execution),
        .pru_done_execution(pru_done_execution), .pru_out(pru_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .error(error), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Processor read model: data for index i is valid exactly two cycles after the READ cycle
    always @(posedge clk) begin
        p1_v <= pru_io_opcode == 3'd4;
        p1_i <= pru_in;
        p2_v <= p1_v;
        p2_i <= p1_i;
    end
    assign pru_out = p2_v ? (32'hA000_0000 | p2_i) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] c, input logic [15:0] n);
        return {c, 12'hABC, n};
    endfunction

    task automatic put(input logic [31:0] w);
        int t = 0;
        host_valid = 1'b1;
        host_data  = w;
        while (!host_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!host_ready) check("put_timeout", 32'(host_ready), 32'd1);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_res(output int t);
        t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic run_exec(input int done_at, output int rp, output int en);
        rp = 0;
        en = 0;
        for (int i = 0; i < 40; i++) begin
            rp += int'(pru_reset_execution);
            if (pru_enable_execution) en++;
            pru_done_execution = pru_enable_execution && en == done_at;
            @(negedge clk);
        end
        pru_done_execution = 1'b0;
    endtask

    initial begin
        int rp, en, t;
        logic [31:0] held;
        repeat (2) @(negedge clk);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_opcode", 32'(pru_io_opcode), 32'd0);
        check("rst_res", {res_valid, res_data[30:0]}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(host_ready), 32'd1);

        put(hdr(4'd1, 16'd3));
        check("cfg_busy", 32'(busy), 32'd1);
        put(32'h1111_AAAA);
        check("cfg_op_a", 32'(pru_io_opcode), 32'd1);
        check("cfg_in_a", pru_in, 32'h1111_AAAA);
        put(32'h2222_BBBB);
        check("cfg_op_b", 32'(pru_io_opcode), 32'd1);
        check("cfg_in_b", pru_in, 32'h2222_BBBB);
        put(32'h3333_CCCC);
        check("cfg_op_c", 32'(pru_io_opcode), 32'd1);
        check("cfg_in_c", pru_in, 32'h3333_CCCC);
        check("cfg_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("cfg_after_op", 32'(pru_io_opcode), 32'd0);
        check("cfg_after_ready", 32'(host_ready), 32'd1);

        put(hdr(4'd3, 16'd2));
        put(32'h0000_5555);
        check("prog_op_x", 32'(pru_io_opcode), 32'd3);
        @(negedge clk);
        check("prog_gap_op", 32'(pru_io_opcode), 32'd0);
        check("prog_gap_busy", 32'(busy), 32'd1);
        put(32'h0000_6666);
        check("prog_op_y", 32'(pru_io_opcode), 32'd3);
        check("prog_in_y", pru_in, 32'h0000_6666);
        check("prog_done_busy", 32'(busy), 32'd0);

        put(hdr(4'd2, 16'd0));
        check("data_n0_busy", 32'(busy), 32'd0);
        check("data_n0_op", 32'(pru_io_opcode), 32'd0);

        put(hdr(4'd4, 16'd77));
        run_exec(10, rp, en);
        check("exec_rst_pulses", 32'(rp), 32'd1);
        check("exec_en_cycles", 32'(en), 32'd10);
        check("exec_cycle_count", cycle_count, 32'd10);
        check("exec_busy", 32'(busy), 32'd0);
        check("exec_error", 32'(error), 32'd0);

        res_ready = 1'b0;
        put(hdr(4'd5, 16'd2));
        check("rd0_op", 32'(pru_io_opcode), 32'd4);
        check("rd0_idx", pru_in, 32'd0);
        check("rd_host_ready", 32'(host_ready), 32'd0);
        wait_res(t);
        check("rd0_latency", 32'(t), 32'd3);
        check("rd0_data", res_data, 32'hA000_0000);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd0_hold_valid", 32'(res_valid), 32'd1);
            check("rd0_hold_data", res_data, held);
            check("rd0_no_issue", 32'(pru_io_opcode), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("rd1_op", 32'(pru_io_opcode), 32'd4);
        check("rd1_idx", pru_in, 32'd1);
        check("rd1_valid_low", 32'(res_valid), 32'd0);
        wait_res(t);
        check("rd1_data", res_data, 32'hA000_0001);
        @(negedge clk);
        res_ready = 1'b0;
        check("rd_end_busy", 32'(busy), 32'd0);
        check("rd_end_valid", 32'(res_valid), 32'd0);

        put(hdr(4'd5, 16'd0));
        check("rd_n0_busy", 32'(busy), 32'd0);
        check("rd_n0_op", 32'(pru_io_opcode), 32'd0);

        put(hdr(4'd4, 16'd0));
        run_exec(0, rp, en);
        check("to_en_cycles", 32'(en), 32'd20);
        check("to_error", 32'(error), 32'd1);
        check("to_host_ready", 32'(host_ready), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
        check("to_cycle_count", cycle_count, 32'd10);
        rst = 1'b1;
        #1;
        check("to_rst_error", 32'(error), 32'd0);
        check("to_rst_cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        put(hdr(4'd7, 16'd1));
        check("bad_error", 32'(error), 32'd1);
        check("bad_ready", 32'(host_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("bad_error_sticky", 32'(error), 32'd1);
        rst = 1'b1;
        #1;
        check("bad_rst_error", 32'(error), 32'd0);
        check("bad_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("bad_ready_after", 32'(host_ready), 32'd1);

        put(hdr(4'd1, 16'd4));
        put(32'hCAFE_0001);
        check("mid_op", 32'(pru_io_opcode), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_op", 32'(pru_io_opcode), 32'd0);
        check("mid_rst_in", pru_in, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(host_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        put(hdr(4'd2, 16'd1));
        put(32'hBEEF_0002);
        check("post_op", 32'(pru_io_opcode), 32'd2);
        check("post_in", pru_in, 32'hBEEF_0002);
        check("post_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
